// File: rtl/axi_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_mem_slave
//
// Memory-backed AXI4-Lite slave. One transaction is in flight at a time,
// sequenced by a six-state FSM (IDLE, RADDR, RDATA, WADDR, WDATA, WRESP).
// Data lives in an internal word array addressed by word index. Every
// output is a flop, so there is no combinational path from any input to
// any output.
//
// Optional feature (compile-time macro):
//   AXIL_SLV_DECERR_EN  - addresses >= MEM_DEPTH return DECERR (2'b11);
//                         reads give zero data, and writes leave the array
//                         untouched. When the macro is undefined, the index
//                         wraps modulo MEM_DEPTH and every response is OKAY.
//
// Parameters:
//   ADDR_WIDTH  address width in bits
//   DATA_WIDTH  data width in bits (multiple of 8); STRB_WIDTH = DATA_WIDTH/8
//   MEM_DEPTH   number of DATA_WIDTH words in the array (<= 2**ADDR_WIDTH)
//
// Ports:
//   aclk                          clock, rising edge
//   areset                        asynchronous, active-high reset
//   ar_addr/ar_valid/ar_ready     read address channel
//   r_data/r_resp/r_valid/r_ready read data channel
//   aw_addr/aw_valid/aw_ready     write address channel
//   w_data/w_strb/w_valid/w_ready write data channel
//   b_resp/b_valid/b_ready        write response channel
// ---------------------------------------------------------------------------
module axi_lite_mem_slave #(
   parameter  int ADDR_WIDTH = 12,
   parameter  int DATA_WIDTH = 8,
   parameter  int MEM_DEPTH  = 4096,
   localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   // read address channel
   input  logic [ADDR_WIDTH-1:0] ar_addr,
   input  logic                  ar_valid,
   output logic                  ar_ready,
   // read data channel
   output logic [DATA_WIDTH-1:0] r_data,
   output logic [1:0]            r_resp,
   output logic                  r_valid,
   input  logic                  r_ready,
   // write address channel
   input  logic [ADDR_WIDTH-1:0] aw_addr,
   input  logic                  aw_valid,
   output logic                  aw_ready,
   // write data channel
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [STRB_WIDTH-1:0] w_strb,
   input  logic                  w_valid,
   output logic                  w_ready,
   // write response channel
   output logic [1:0]            b_resp,
   output logic                  b_valid,
   input  logic                  b_ready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WADDR = 3'd3,
      WDATA = 3'd4,
      WRESP = 3'd5
   } state_type;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   state_type             r_state;
   state_type             w_next_state;
   logic                  r_last_rd;     // 1 = most recent served transaction was a read
   logic [ADDR_WIDTH-1:0] r_addr;        // address latched in RADDR/WADDR

   logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

   logic [IDX_WIDTH-1:0]  w_rd_idx;
   logic [IDX_WIDTH-1:0]  w_wr_idx;
   logic                  w_rd_err;
   logic                  w_wr_err;
   logic                  w_mem_we;

   // Word index of an address; out-of-range addresses wrap modulo MEM_DEPTH.
   // The arithmetic is done at 32 bits so MEM_DEPTH == 2**ADDR_WIDTH cannot
   // collapse to a divide-by-zero at ADDR_WIDTH bits.
   function automatic logic [IDX_WIDTH-1:0] to_index(input logic [ADDR_WIDTH-1:0] addr);
      return IDX_WIDTH'(32'(addr) % 32'(MEM_DEPTH));
   endfunction

   // Reads index straight off ar_addr because the array is sampled in the
   // same RADDR cycle that latches the address.
   assign w_rd_idx = to_index(ar_addr);
   assign w_wr_idx = to_index(r_addr);

`ifdef AXIL_SLV_DECERR_EN
   assign w_rd_err = (32'(ar_addr) >= 32'(MEM_DEPTH));
   assign w_wr_err = (32'(r_addr)  >= 32'(MEM_DEPTH));
`else
   assign w_rd_err = 1'b0;
   assign w_wr_err = 1'b0;
`endif

   // -------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------
   // NOTE: the default assignment up front covers every path through the
   // case, so no latch is inferred for w_next_state.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            // Both pending: serve the opposite type to the last one served.
            if (ar_valid && (!aw_valid || !r_last_rd)) begin
               w_next_state = RADDR;
            end else if (aw_valid) begin
               w_next_state = WADDR;
            end
         end
         RADDR:   w_next_state = RDATA;
         RDATA:   if (r_ready) w_next_state = IDLE;
         WADDR:   w_next_state = WDATA;
         WDATA:   if (w_valid) w_next_state = WRESP;
         WRESP:   if (b_ready) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // -------------------------------------------------------------------
   // State register and arbitration flag
   // -------------------------------------------------------------------
   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge values, independent of block ordering in simulation.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_state   <= IDLE;
         r_last_rd <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == RADDR) r_last_rd <= 1'b1;
         if (r_state == WADDR) r_last_rd <= 1'b0;
      end
   end

   // -------------------------------------------------------------------
   // Handshake outputs: registered decodes of the next state, so each one
   // is high exactly while the FSM sits in its state.
   // -------------------------------------------------------------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ar_ready <= 1'b0;
         aw_ready <= 1'b0;
         w_ready  <= 1'b0;
         r_valid  <= 1'b0;
         b_valid  <= 1'b0;
      end else begin
         ar_ready <= (w_next_state == RADDR);
         aw_ready <= (w_next_state == WADDR);
         w_ready  <= (w_next_state == WDATA);
         r_valid  <= (w_next_state == RDATA);
         b_valid  <= (w_next_state == WRESP);
      end
   end

   // -------------------------------------------------------------------
   // Address latch and response/data registers. r_data and r_resp load
   // only in RADDR, so they stay stable for the whole RDATA stall.
   // -------------------------------------------------------------------
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         r_addr <= '0;
         r_data <= '0;
         r_resp <= RESP_OKAY;
         b_resp <= RESP_OKAY;
      end else begin
         if (r_state == RADDR) begin
            r_addr <= ar_addr;
            r_data <= w_rd_err ? '0 : r_mem[w_rd_idx];
            r_resp <= w_rd_err ? RESP_DECERR : RESP_OKAY;
         end
         if (r_state == WADDR) begin
            r_addr <= aw_addr;
         end
         if ((r_state == WDATA) && w_valid) begin
            b_resp <= w_wr_err ? RESP_DECERR : RESP_OKAY;
         end
      end
   end

   // -------------------------------------------------------------------
   // Storage array with per-byte write enables
   // -------------------------------------------------------------------
   assign w_mem_we = (r_state == WDATA) && w_valid && !w_wr_err;

   // NOTE: the array has no reset on purpose; its contents survive areset,
   // and leaving it out of the reset tree lets it map onto RAM.
   always_ff @(posedge aclk) begin
      if (w_mem_we) begin
         for (int i = 0; i < STRB_WIDTH; i++) begin
            if (w_strb[i]) begin
               r_mem[w_wr_idx][i*8 +: 8] <= w_data[i*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_mem_slave
//
// Directed testbench for axi_lite_mem_slave (MEM_DEPTH = 16). Inputs are
// driven 1 time unit after the rising edge and outputs are sampled on the
// falling edge. Cycle numbers are counted from the cycle in which a valid
// signal is first presented (cycle 0). The decode scenario follows
// AXIL_SLV_DECERR_EN, matching the way the design is built.
// ---------------------------------------------------------------------------
module tb_axi_lite_mem_slave;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          aclk;
   logic          areset;
   logic [AW-1:0] ar_addr;
   logic          ar_valid;
   logic          ar_ready;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic          r_valid;
   logic          r_ready;
   logic [AW-1:0] aw_addr;
   logic          aw_valid;
   logic          aw_ready;
   logic [DW-1:0] w_data;
   logic [0:0]    w_strb;
   logic          w_valid;
   logic          w_ready;
   logic [1:0]    b_resp;
   logic          b_valid;
   logic          b_ready;

   int n_checks = 0;
   int n_fail   = 0;

   axi_lite_mem_slave #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_DEPTH  (DEPTH)
   ) dut (
      .aclk     (aclk),
      .areset   (areset),
      .ar_addr  (ar_addr),
      .ar_valid (ar_valid),
      .ar_ready (ar_ready),
      .r_data   (r_data),
      .r_resp   (r_resp),
      .r_valid  (r_valid),
      .r_ready  (r_ready),
      .aw_addr  (aw_addr),
      .aw_valid (aw_valid),
      .aw_ready (aw_ready),
      .w_data   (w_data),
      .w_strb   (w_strb),
      .w_valid  (w_valid),
      .w_ready  (w_ready),
      .b_resp   (b_resp),
      .b_valid  (b_valid),
      .b_ready  (b_ready)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Hard stop in case a scenario wedges outside its own bounded waits.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no end, want summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Full write transaction; reports the response and the cycle of each phase.
   task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [0:0] strb, output logic [1:0] resp,
                            output int aw_cyc, output int w_cyc, output int b_cyc);
      int cyc;
      aw_cyc = -1; w_cyc = -1; b_cyc = -1; resp = 2'bxx; cyc = 0;
      tick();
      aw_addr = addr; aw_valid = 1'b1; b_ready = 1'b0;
      while (aw_cyc < 0 && cyc < 20) begin
         @(negedge aclk);
         if (aw_ready === 1'b1) aw_cyc = cyc;
         tick(); cyc++;
      end
      aw_valid = 1'b0; w_data = data; w_strb = strb; w_valid = 1'b1; b_ready = 1'b1;
      while (w_cyc < 0 && cyc < 40) begin
         @(negedge aclk);
         if (w_ready === 1'b1) w_cyc = cyc;
         tick(); cyc++;
      end
      w_valid = 1'b0;
      while (b_cyc < 0 && cyc < 60) begin
         @(negedge aclk);
         if (b_valid === 1'b1) begin b_cyc = cyc; resp = b_resp; end
         tick(); cyc++;
      end
      b_ready = 1'b0;
   endtask

   // Full read transaction with r_ready already high in the first data cycle.
   task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp, output int ar_cyc, output int r_cyc);
      int cyc;
      ar_cyc = -1; r_cyc = -1; data = 'x; resp = 2'bxx; cyc = 0;
      tick();
      ar_addr = addr; ar_valid = 1'b1; r_ready = 1'b0;
      while (ar_cyc < 0 && cyc < 20) begin
         @(negedge aclk);
         if (ar_ready === 1'b1) ar_cyc = cyc;
         tick(); cyc++;
      end
      ar_valid = 1'b0; r_ready = 1'b1;
      while (r_cyc < 0 && cyc < 40) begin
         @(negedge aclk);
         if (r_valid === 1'b1) begin r_cyc = cyc; data = r_data; resp = r_resp; end
         tick(); cyc++;
      end
      r_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge aclk);
      n_checks++; if (ar_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ar_ready: got %b want 0", ar_ready); end
      n_checks++; if (aw_ready !== 1'b0) begin n_fail++; $display("FAIL reset_aw_ready: got %b want 0", aw_ready); end
      n_checks++; if (w_ready  !== 1'b0) begin n_fail++; $display("FAIL reset_w_ready: got %b want 0", w_ready); end
      n_checks++; if (r_valid  !== 1'b0) begin n_fail++; $display("FAIL reset_r_valid: got %b want 0", r_valid); end
      n_checks++; if (b_valid  !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
      n_checks++; if (r_data   !== 8'h00) begin n_fail++; $display("FAIL reset_r_data: got %h want 00", r_data); end
      n_checks++; if (r_resp   !== 2'b00) begin n_fail++; $display("FAIL reset_r_resp: got %b want 00", r_resp); end
      n_checks++; if (b_resp   !== 2'b00) begin n_fail++; $display("FAIL reset_b_resp: got %b want 00", b_resp); end
      tick();
      areset = 1'b0;
      @(negedge aclk);
      n_checks++; if ({ar_ready, aw_ready, w_ready, r_valid, b_valid} !== 5'b0)
         begin n_fail++; $display("FAIL idle_after_reset: got %b want 00000", {ar_ready, aw_ready, w_ready, r_valid, b_valid}); end
   endtask

   task automatic test_basic_write_read();
      logic [1:0] resp; logic [DW-1:0] d; int c0, c1, c2;
      axi_write(12'h004, 8'hA5, 1'b1, resp, c0, c1, c2);
      n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL wr_b_resp: got %b want 00", resp); end
      n_checks++; if (c0 !== 1) begin n_fail++; $display("FAIL wr_aw_ready_cycle: got %0d want 1", c0); end
      n_checks++; if (c1 !== 2) begin n_fail++; $display("FAIL wr_w_ready_cycle: got %0d want 2", c1); end
      n_checks++; if (c2 !== 3) begin n_fail++; $display("FAIL wr_b_valid_cycle: got %0d want 3", c2); end
      axi_read(12'h004, d, resp, c0, c1);
      n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL rd_data_004: got %h want a5", d); end
      n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL rd_resp_004: got %b want 00", resp); end
      n_checks++; if (c0 !== 1) begin n_fail++; $display("FAIL rd_ar_ready_cycle: got %0d want 1", c0); end
      n_checks++; if (c1 !== 2) begin n_fail++; $display("FAIL rd_r_valid_cycle: got %0d want 2", c1); end
      axi_write(12'h001, 8'h11, 1'b1, resp, c0, c1, c2);
      axi_write(12'h002, 8'h22, 1'b1, resp, c0, c1, c2);
      axi_read(12'h001, d, resp, c0, c1);
      n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL rd_data_001: got %h want 11", d); end
      axi_read(12'h002, d, resp, c0, c1);
      n_checks++; if (d !== 8'h22) begin n_fail++; $display("FAIL rd_data_002: got %h want 22", d); end
   endtask

   task automatic test_zero_strobe();
      logic [1:0] resp; logic [DW-1:0] d; int c0, c1, c2;
      axi_write(12'h004, 8'h3C, 1'b0, resp, c0, c1, c2);
      n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL zs_b_resp: got %b want 00", resp); end
      n_checks++; if (c2 !== 3) begin n_fail++; $display("FAIL zs_b_valid_cycle: got %0d want 3", c2); end
      axi_read(12'h004, d, resp, c0, c1);
      n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL zs_rd_data: got %h want a5", d); end
   endtask

   task automatic test_arbitration();
      areset = 1'b1; tick(); tick(); areset = 1'b0;
      // c0: both requests pending after reset
      tick(); ar_addr = 12'h004; ar_valid = 1'b1; aw_addr = 12'h008; aw_valid = 1'b1;
      @(negedge aclk);
      n_checks++; if ({ar_ready, aw_ready} !== 2'b00) begin n_fail++; $display("FAIL arb_c0_idle: got %b want 00", {ar_ready, aw_ready}); end
      tick(); @(negedge aclk);
      n_checks++; if ({ar_ready, aw_ready} !== 2'b10) begin n_fail++; $display("FAIL arb_first_read: got %b want 10", {ar_ready, aw_ready}); end
      tick(); ar_valid = 1'b0; r_ready = 1'b1; @(negedge aclk);
      n_checks++; if ({r_valid, r_data} !== {1'b1, 8'hA5}) begin n_fail++; $display("FAIL arb_first_rdata: got %b/%h want 1/a5", r_valid, r_data); end
      tick(); r_ready = 1'b0; ar_addr = 12'h008; ar_valid = 1'b1; @(negedge aclk);
      tick(); @(negedge aclk);
      n_checks++; if ({ar_ready, aw_ready} !== 2'b01) begin n_fail++; $display("FAIL arb_second_write: got %b want 01", {ar_ready, aw_ready}); end
      tick(); aw_valid = 1'b0; w_data = 8'h5A; w_strb = 1'b1; w_valid = 1'b1; b_ready = 1'b1; @(negedge aclk);
      n_checks++; if (w_ready !== 1'b1) begin n_fail++; $display("FAIL arb_w_ready: got %b want 1", w_ready); end
      tick(); w_valid = 1'b0; @(negedge aclk);
      n_checks++; if ({b_valid, b_resp, ar_ready} !== 4'b1000) begin n_fail++; $display("FAIL arb_bresp: got %b want 1000", {b_valid, b_resp, ar_ready}); end
      tick(); b_ready = 1'b0; aw_addr = 12'h00C; aw_valid = 1'b1; @(negedge aclk);
      tick(); @(negedge aclk);
      n_checks++; if ({ar_ready, aw_ready} !== 2'b10) begin n_fail++; $display("FAIL arb_third_read: got %b want 10", {ar_ready, aw_ready}); end
      tick(); ar_valid = 1'b0; r_ready = 1'b1; @(negedge aclk);
      n_checks++; if ({r_valid, r_data} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL arb_raw_rdata: got %b/%h want 1/5a", r_valid, r_data); end
      tick(); r_ready = 1'b0; @(negedge aclk);
      tick(); @(negedge aclk);
      n_checks++; if (aw_ready !== 1'b1) begin n_fail++; $display("FAIL arb_fourth_write: got %b want 1", aw_ready); end
      tick(); aw_valid = 1'b0; w_data = 8'hC3; w_strb = 1'b1; w_valid = 1'b1; b_ready = 1'b1; @(negedge aclk);
      tick(); w_valid = 1'b0; @(negedge aclk);
      n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL arb_fourth_bvalid: got %b want 1", b_valid); end
      tick(); b_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      tick(); ar_addr = 12'h004; ar_valid = 1'b1; r_ready = 1'b0; @(negedge aclk);
      tick(); @(negedge aclk);
      n_checks++; if (ar_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ar_ready: got %b want 1", ar_ready); end
      tick(); ar_addr = 12'h008;   // second request held pending during the stall
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         n_checks++; if ({r_valid, r_data, r_resp, ar_ready} !== {1'b1, 8'hA5, 2'b00, 1'b0})
            begin n_fail++; $display("FAIL bp_stall_%0d: got %b/%h/%b/%b want 1/a5/00/0", i, r_valid, r_data, r_resp, ar_ready); end
         tick();
      end
      r_ready = 1'b1; @(negedge aclk);
      n_checks++; if ({r_valid, ar_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_release: got %b want 10", {r_valid, ar_ready}); end
      tick(); r_ready = 1'b0; @(negedge aclk);
      n_checks++; if ({ar_ready, r_valid} !== 2'b00) begin n_fail++; $display("FAIL bp_idle: got %b want 00", {ar_ready, r_valid}); end
      tick(); @(negedge aclk);
      n_checks++; if (ar_ready !== 1'b1) begin n_fail++; $display("FAIL bp_second_ar_ready: got %b want 1", ar_ready); end
      tick(); ar_valid = 1'b0; r_ready = 1'b1; @(negedge aclk);
      n_checks++; if ({r_valid, r_data} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL bp_second_rdata: got %b/%h want 1/5a", r_valid, r_data); end
      tick(); r_ready = 1'b0;
   endtask

   task automatic test_decode();
      logic [1:0] resp; logic [DW-1:0] d; int c0, c1, c2;
      axi_write(12'h00F, 8'hE1, 1'b1, resp, c0, c1, c2);
      axi_read(12'h00F, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'hE1, 2'b00}) begin n_fail++; $display("FAIL dec_last_word: got %h/%b want e1/00", d, resp); end
      axi_write(12'h014, 8'h77, 1'b1, resp, c0, c1, c2);
`ifdef AXIL_SLV_DECERR_EN
      n_checks++; if (resp !== 2'b11) begin n_fail++; $display("FAIL dec_wr_resp: got %b want 11", resp); end
      axi_read(12'h004, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'hA5, 2'b00}) begin n_fail++; $display("FAIL dec_rd_004: got %h/%b want a5/00", d, resp); end
      axi_read(12'h014, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL dec_rd_014: got %h/%b want 00/11", d, resp); end
      axi_read(12'h010, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'h00, 2'b11}) begin n_fail++; $display("FAIL dec_rd_010: got %h/%b want 00/11", d, resp); end
`else
      n_checks++; if (resp !== 2'b00) begin n_fail++; $display("FAIL dec_wr_resp: got %b want 00", resp); end
      axi_read(12'h004, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'h77, 2'b00}) begin n_fail++; $display("FAIL dec_rd_004: got %h/%b want 77/00", d, resp); end
      axi_read(12'h014, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'h77, 2'b00}) begin n_fail++; $display("FAIL dec_rd_014: got %h/%b want 77/00", d, resp); end
      axi_read(12'h01F, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'hE1, 2'b00}) begin n_fail++; $display("FAIL dec_rd_01f: got %h/%b want e1/00", d, resp); end
`endif
   endtask

   task automatic test_reset_mid_op();
      logic [1:0] resp; logic [DW-1:0] d; int c0, c1;
      // Read stalled in RDATA, then reset between clock edges.
      tick(); ar_addr = 12'h00C; ar_valid = 1'b1; r_ready = 1'b0;
      tick();
      tick(); ar_valid = 1'b0; @(negedge aclk);
      n_checks++; if ({r_valid, r_data} !== {1'b1, 8'hC3}) begin n_fail++; $display("FAIL rst_pre_rdata: got %b/%h want 1/c3", r_valid, r_data); end
      #1 areset = 1'b1;
      #1;
      n_checks++; if ({r_valid, r_data} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL rst_async_drop: got %b/%h want 0/00", r_valid, r_data); end
      tick(); tick(); @(negedge aclk);
      n_checks++; if ({ar_ready, aw_ready, w_ready, r_valid, b_valid} !== 5'b0)
         begin n_fail++; $display("FAIL rst_held_outputs: got %b want 00000", {ar_ready, aw_ready, w_ready, r_valid, b_valid}); end
      #2 areset = 1'b0;
      axi_read(12'h00C, d, resp, c0, c1);
      n_checks++; if ({d, resp} !== {8'hC3, 2'b00}) begin n_fail++; $display("FAIL rst_fresh_read: got %h/%b want c3/00", d, resp); end
      n_checks++; if (c1 !== 2) begin n_fail++; $display("FAIL rst_fresh_latency: got %0d want 2", c1); end
      // Write clocked in WDATA, reset while in WRESP: the array keeps the data.
      tick(); aw_addr = 12'h003; aw_valid = 1'b1; b_ready = 1'b0;
      tick();
      tick(); aw_valid = 1'b0; w_data = 8'h9D; w_strb = 1'b1; w_valid = 1'b1;
      tick(); w_valid = 1'b0; @(negedge aclk);
      n_checks++; if (b_valid !== 1'b1) begin n_fail++; $display("FAIL rst_wresp_valid: got %b want 1", b_valid); end
      #1 areset = 1'b1;
      #1;
      n_checks++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL rst_b_valid_drop: got %b want 0", b_valid); end
      tick(); @(negedge aclk);
      #2 areset = 1'b0;
      axi_read(12'h003, d, resp, c0, c1);
      n_checks++; if (d !== 8'h9D) begin n_fail++; $display("FAIL rst_write_persists: got %h want 9d", d); end
   endtask

   initial begin
      areset   = 1'b1;
      ar_addr  = '0; ar_valid = 1'b0; r_ready = 1'b0;
      aw_addr  = '0; aw_valid = 1'b0;
      w_data   = '0; w_strb   = 1'b0; w_valid = 1'b0;
      b_ready  = 1'b0;

      test_reset();
      test_basic_write_read();
      test_zero_strobe();
      test_arbitration();
      test_backpressure();
      test_decode();
      test_reset_mid_op();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
